// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the uart transmitter.
// master: arbiter side; slave: client/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [7:0]        uart_din;
    logic              uart_wr_en;
    logic              uart_wr_rdy;
    logic [2:0]        grant_id;
    logic              busy;
    logic              err;

    modport master (
        input  req, data, uart_wr_rdy,
        output ack, uart_din, uart_wr_en, grant_id, busy, err
    );

    modport slave (
        output req, data, uart_wr_rdy,
        input  ack, uart_din, uart_wr_en, grant_id, busy, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NREQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, ptr held at 0).
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_arbiter_if.master      bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state_q;
    logic [2:0]      ptr_q;
    logic [7:0]      cnt_q;
    logic [NREQ-1:0] ack_q;
    logic [7:0]      din_q;
    logic            wr_en_q;
    logic [2:0]      grant_q;
    logic            busy_q;
    logic            err_q;

    logic            pick_vld;
    logic [2:0]      pick_idx;

    // Scan starting at ptr_q, wrapping modulo NREQ; the first set request wins.
    always_comb begin
        int unsigned idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_vld && bus.req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            din_q   <= '0;
            wr_en_q <= 1'b0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q   <= '0;
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld && bus.uart_wr_rdy) begin
                        din_q   <= bus.data[8*pick_idx +: 8];
                        grant_q <= pick_idx;
                        ack_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
`ifndef UART_ARB_FIXED_PRIO_EN
                        ptr_q   <= (32'(pick_idx) + 32'd1 == NREQ) ? 3'd0 : pick_idx + 3'd1;
`endif
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    wr_en_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Ready dropping takes precedence over a timeout in the same cycle.
                    if (!bus.uart_wr_rdy) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == 8'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.uart_wr_rdy) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.uart_din   = din_q;
    assign bus.uart_wr_en = wr_en_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model (FRAME cycles not ready per byte).
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned FRAME   = 6;

    logic clk = 1'b0;
    logic rst;

    uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic        model_en;
    logic        manual_rdy;
    logic        model_rdy;
    int unsigned fcnt;

    assign bus.uart_wr_rdy = model_en ? model_rdy : manual_rdy;

    // Transmitter model: accepts wr_en while ready, then stays busy for FRAME cycles.
    always @(posedge clk) begin
        if (!model_en) begin
            model_rdy <= 1'b1;
            fcnt      <= 0;
        end else if (model_rdy && bus.uart_wr_en) begin
            model_rdy <= 1'b0;
            fcnt      <= FRAME;
        end else if (!model_rdy) begin
            if (fcnt == 1) model_rdy <= 1'b1;
            fcnt <= fcnt - 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.req    = '0;
        bus.data   = '0;
        model_en   = 1'b0;
        manual_rdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack: got %b want 0000", bus.ack); else passed++;
        total++; if (bus.uart_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", bus.uart_wr_en); else passed++;
        total++; if (bus.uart_din !== 8'h00) $display("FAIL reset_din: got %h want 00", bus.uart_din); else passed++;
        total++; if (bus.grant_id !== 3'd0) $display("FAIL reset_grant: got %0d want 0", bus.grant_id); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else passed++;
    endtask

    task automatic test_single();
        int  cyc;
        int  extra_wr;
        int  err_seen;
        bit  held;
        do_reset();
        model_en       = 1'b1;
        bus.req        = 4'b0001;
        bus.data[7:0]  = 8'hA5;
        tick();
        total++; if (bus.ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", bus.ack); else passed++;
        total++; if (bus.uart_din !== 8'hA5) $display("FAIL single_din: got %h want a5", bus.uart_din); else passed++;
        total++; if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else passed++;
        bus.req       = 4'b0000;
        bus.data[7:0] = 8'hFF;
        tick();
        total++; if (bus.ack !== 4'b0000 || bus.uart_wr_en !== 1'b1)
            $display("FAIL single_wr_en: got ack=%b wr_en=%b want ack=0000 wr_en=1", bus.ack, bus.uart_wr_en);
        else passed++;
        held = 1'b1; extra_wr = 0; err_seen = 0; cyc = 0;
        while (bus.busy === 1'b1 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.uart_din !== 8'hA5) held = 1'b0;
            if (bus.uart_wr_en === 1'b1) extra_wr++;
            if (bus.err === 1'b1) err_seen++;
        end
        total++; if (bus.busy !== 1'b0) $display("FAIL single_done: busy=%b after %0d cycles want 0", bus.busy, cyc); else passed++;
        total++; if (!held) $display("FAIL single_din_hold: din changed during frame want a5"); else passed++;
        total++; if (extra_wr != 0 || err_seen != 0)
            $display("FAIL single_extra: got wr_en=%0d err=%0d want 0 0", extra_wr, err_seen);
        else passed++;
    endtask

    task automatic test_round_robin();
        int unsigned exp_idx [5];
        int          n;
        int          cyc;
        logic [3:0]  exp_ack;
        logic [7:0]  exp_din;
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_idx = '{0, 0, 0, 0, 0};
`else
        exp_idx = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        model_en = 1'b1;
        bus.data = 32'h13121110;
        bus.req  = 4'b1111;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 300) begin
            tick();
            cyc++;
            if (bus.ack !== 4'b0000) begin
                exp_ack = 4'b0001 << exp_idx[n];
                exp_din = 8'h10 + 8'(exp_idx[n]);
                total++; if (bus.ack !== exp_ack) $display("FAIL rr_ack%0d: got %b want %b", n, bus.ack, exp_ack); else passed++;
                total++; if (bus.uart_din !== exp_din) $display("FAIL rr_din%0d: got %h want %h", n, bus.uart_din, exp_din); else passed++;
                n++;
            end
        end
        total++; if (n != 5) $display("FAIL rr_count: got %0d grants want 5", n); else passed++;
        bus.req = '0;
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        bus.req       = 4'b0001;
        bus.data[7:0] = 8'h5A;
        tick();
        bus.req = 4'b0000;
        tick();
        total++; if (bus.uart_wr_en !== 1'b1) $display("FAIL to_wr_en: got %b want 1", bus.uart_wr_en); else passed++;
        early = 0;
        for (int k = 1; k <= int'(TIMEOUT) + 1; k++) begin
            tick();
            if (k <= int'(TIMEOUT) && bus.err === 1'b1) early++;
        end
        total++; if (early != 0) $display("FAIL to_early: err seen %0d times before cycle %0d", early, TIMEOUT + 1); else passed++;
        total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL to_err: got err=%b busy=%b want err=1 busy=0", bus.err, bus.busy);
        else passed++;
        tick();
        total++; if (bus.err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", bus.err); else passed++;
        bus.req = 4'b0010;
        tick();
        total++; if (bus.ack !== 4'b0010) $display("FAIL to_next_ack: got %b want 0010", bus.ack); else passed++;
        bus.req = '0;
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        bus.req        = 4'b0010;
        bus.data[15:8] = 8'hC3;
        tick();
        bus.req = 4'b0000;
        tick();
        manual_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.ack !== 4'b0000 || bus.uart_wr_en !== 1'b0 || bus.err !== 1'b0)
            $display("FAIL mid_rst_pulses: got ack=%b wr_en=%b err=%b want 0", bus.ack, bus.uart_wr_en, bus.err);
        else passed++;
        total++; if (bus.uart_din !== 8'h00) $display("FAIL mid_rst_din: got %h want 00", bus.uart_din); else passed++;
        total++; if (bus.grant_id !== 3'd0) $display("FAIL mid_rst_grant: got %0d want 0", bus.grant_id); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", bus.busy); else passed++;
        rst        = 1'b0;
        manual_rdy = 1'b1;
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.uart_wr_en !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        total++; if (stray != 0) $display("FAIL mid_rst_resend: activity in %0d cycles want 0", stray); else passed++;
        // ptr was 2 before reset; after reset the scan must start at 0 again.
        bus.req = 4'b0101;
        tick();
        total++; if (bus.ack !== 4'b0001) $display("FAIL mid_rst_ptr: got %b want 0001", bus.ack); else passed++;
        bus.req = '0;
    endtask

    task automatic test_rdy_low();
        int early;
        do_reset();
        manual_rdy = 1'b0;
        bus.req    = 4'b0010;
        early = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.ack !== 4'b0000 || bus.busy !== 1'b0) early++;
        end
        total++; if (early != 0) $display("FAIL rdy_low_hold: granted in %0d cycles want 0", early); else passed++;
        manual_rdy = 1'b1;
        tick();
        total++; if (bus.ack !== 4'b0010) $display("FAIL rdy_low_ack: got %b want 0010", bus.ack); else passed++;
        bus.req = '0;
    endtask

    task automatic test_drop();
        int wr_cnt;
        int ack3;
        do_reset();
        model_en      = 1'b1;
        bus.req       = 4'b0001;
        bus.data[7:0] = 8'h3C;
        tick();
        bus.req = 4'b0000;
        tick();
        wr_cnt = (bus.uart_wr_en === 1'b1) ? 1 : 0;
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b0000;
        ack3 = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.uart_wr_en === 1'b1) wr_cnt++;
            if (bus.ack !== 4'b0000) ack3++;
            tick();
        end
        total++; if (ack3 != 0) $display("FAIL drop_ack: got %0d ack cycles want 0", ack3); else passed++;
        total++; if (wr_cnt != 1) $display("FAIL drop_wr_en: got %0d pulses want 1", wr_cnt); else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        bus.req    = '0;
        bus.data   = '0;
        model_en   = 1'b0;
        manual_rdy = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_rdy_low();
        test_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
